div_seq: RTL
============

Name: div_seq

Overview:
- Parametrised multi-cycle sequential divider for the EX stage; serves DIV/DIVU.
- Replaces single-cycle EX arithmetic for division. EX holds the pipeline stalled until ready_o, then forwards result_o to the hilo write path (lo = quotient, hi = remainder).
- Radix-2 restoring algorithm, one quotient bit per cycle.
- Adds signed/unsigned mode, divide-by-zero short path and annul (cancel on flush).

Parameters:
- WIDTH, 32, operand width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; localparam derived from WIDTH, not overridable.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept.
- opdata1_i  in  WIDTH  dividend; sampled at accept.
- opdata2_i  in  WIDTH  divisor; sampled at accept.
- start_i  in  1  request; level-held by EX until ready_o seen.
- annul_i  in  1  cancel the in-flight division (pipeline flush).
- result_o  out  2*WIDTH  {remainder, quotient}; registered.
- ready_o  out  1  result_o valid; registered.

Behaviour:
- Reset: rst=1 at a clock edge forces state=FREE, cnt=0, result_o=0, ready_o=0. This applies in any state, including mid-ON, and the partial result is discarded.
- States: FREE, BY_ZERO, ON, END. Encoding constants live in the shared package.
- FREE:
  - start_i=1 & annul_i=0 & opdata2_i==0 -> BY_ZERO.
  - start_i=1 & annul_i=0 & opdata2_i!=0 -> ON. This is the accept edge: latch operands and mode, cnt=0.
  - In signed mode, negative operands are converted to magnitude (two's complement) at accept.
  - Otherwise stay in FREE; ready_o=0, result_o=0.
- BY_ZERO: next cycle -> END with result_o=0 (quotient 0, remainder 0).
- ON:
  - Each cycle: shift {rem, dividend} left 1; trial subtract divisor; if no borrow keep the difference and set quotient bit 1, else restore and set bit 0. Then cnt++.
  - After exactly WIDTH iterations (cnt==WIDTH) -> END.
  - Sign fixup, signed mode only: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - annul_i=1 in ON -> FREE next edge; ready_o stays 0 and result_o=0.
  - start_i deasserting during ON is ignored; annul_i is the only cancel.
  - Operand inputs changing during ON are ignored.
- Latency, division by nonzero:
  - Accept edge = edge 0.
  - ON occupies edges 1..WIDTH.
  - ready_o=1 from the cycle after edge WIDTH+1, i.e. WIDTH+1 edges after accept.
- Latency, divide by zero: ready_o=1 two edges after accept.
- END:
  - ready_o=1 and result_o held stable.
  - Stay in END while start_i=1.
  - start_i=0 -> FREE next edge, clearing ready_o and result_o.
  - annul_i=1 in END -> FREE.
- Signed overflow, MIN / -1: quotient wraps to MIN, remainder 0. No exception is raised.
- Magnitude of MIN is MIN treated as unsigned (2^(WIDTH-1)), which gives the correct result.
- Simultaneous start_i & annul_i in FREE: annul wins, stay in FREE.
- Back-to-back requests: a new accept is only possible from FREE, so start_i must drop for at least one cycle between divisions.

Decomposition:
- Shared defines/package: DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END state codes (2 bits).
- Shared defines/package: DivResultNotReady / DivResultReady, DivStart / DivStop, and the DIV/DIVU aluop codes used by EX to drive signed_div_i.
- Single module, no sub-module: the datapath is one trial subtractor plus a shift register, and the FSM is small.

Test Plan:
- WIDTH=32 unsigned 100/7, start held -> ready_o rises 33 edges after accept; result_o={32'd2, 32'd14}. Drop start_i -> ready_o=0 next edge.
- WIDTH=32 signed -7/2 (0xFFFFFFF9 / 0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7/-2 -> quotient 0xFFFFFFFD, remainder 0x1.
- Divide by zero, 0x1234 / 0 -> ready_o=1 two edges after accept; result_o=0.
- annul_i pulsed 10 edges after accept of 1000/3 -> FREE next edge, ready_o never asserts. A new start 50/5 is then accepted and returns q=10, r=0.
- Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0. Also rst asserted mid-ON -> all outputs 0 next edge, FSM in FREE.
- WIDTH=8 instance, unsigned 200/3 -> ready_o 9 edges after accept; q=8'd66, r=8'd2.

Source files
------------

// File: rtl/div_seq_pkg.sv
// div_seq_pkg: FSM state codes, handshake levels and EX aluop codes for the sequential divider
package div_seq_pkg;
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: EX<->divider bus (master drives signed_div_i/opdata1_i/opdata2_i/start_i/annul_i, slave returns result_o={rem,quot}/ready_o)
interface div_seq_if #(parameter int WIDTH = 32);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  modport master (output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i, input result_o, ready_o);
  modport slave  (input signed_div_i, opdata1_i, opdata2_i, start_i, annul_i, output result_o, ready_o);
endinterface

// File: rtl/div_seq.sv
// div_seq: radix-2 restoring DIV/DIVU, one quotient bit per cycle; ports clk, rst (sync high), bus (div_seq_if.slave)
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  div_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  div_state_e         r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_dvd, r_dvs, r_rem;
  logic               r_neg_q, r_neg_r;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;
  logic [WIDTH:0]     w_shift, w_diff;
  logic [WIDTH-1:0]   w_op1_abs, w_op2_abs, w_q, w_r;
  logic               w_op1_neg, w_op2_neg, w_zero, w_last, w_hold;
  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;
  always_comb begin
    w_op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    w_op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    w_op1_abs = w_op1_neg ? -bus.opdata1_i : bus.opdata1_i;
    w_op2_abs = w_op2_neg ? -bus.opdata2_i : bus.opdata2_i;
    w_zero    = bus.opdata2_i == '0;
    w_shift   = {r_rem, r_dvd[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_dvs};
    w_last    = r_cnt == CNT_W'(WIDTH - 1);
    w_q       = r_neg_q ? -r_dvd : r_dvd;
    w_r       = r_neg_r ? -r_rem : r_rem;
    w_next    = r_state;
    unique case (r_state)
      DIV_FREE:    w_next = (bus.start_i & ~bus.annul_i) ? (w_zero ? DIV_BY_ZERO : DIV_ON) : DIV_FREE;
      DIV_BY_ZERO: w_next = bus.annul_i ? DIV_FREE : DIV_END;
      DIV_ON:      w_next = bus.annul_i ? DIV_FREE : (w_last ? DIV_END : DIV_ON);
      DIV_END:     w_next = (bus.annul_i | ~bus.start_i) ? DIV_FREE : DIV_END;
      default:     w_next = DIV_FREE;
    endcase
    w_hold = (r_state == DIV_END) & (w_next == DIV_END);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DIV_FREE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= DivResultNotReady;
    end else begin
      r_state  <= w_next;
      r_ready  <= w_hold ? DivResultReady : DivResultNotReady;
      r_result <= w_hold ? {w_r, w_q} : '0;
      if (r_state == DIV_FREE) begin
        r_cnt   <= '0;
        r_rem   <= '0;
        r_dvd   <= w_zero ? '0 : w_op1_abs;
        r_dvs   <= w_op2_abs;
        r_neg_q <= w_op1_neg ^ w_op2_neg;
        r_neg_r <= w_op1_neg;
      end else if (r_state == DIV_ON) begin
        r_rem <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        r_dvd <= {r_dvd[WIDTH-2:0], ~w_diff[WIDTH]};
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end
endmodule
